// File: rtl/wrsched_pkg.sv
// Shared definitions for the DRAM write scheduler: FSM state encoding,
// default block size and the way-count ceiling, plus a way-index wrap helper.
package wrsched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } wrsched_state_e;

  localparam int unsigned WRSCHED_BLK_BYTES = 64;
  localparam int unsigned WRSCHED_MAX_WAYS  = 4;

  // Wrap a way index that may have run one lap past the way count.
  function automatic logic [1:0] wrap_way(input logic [2:0] v, input logic [2:0] ways);
    logic [2:0] r;
    if (v >= ways) begin
      r = v - ways;
    end else begin
      r = v;
    end
    return r[1:0];
  endfunction

endpackage

// File: rtl/dram_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping at WAYS) receives a one-hot grant and its index.
module rr_arbiter
  import wrsched_pkg::*;
#(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-1:0] req,
  input  logic [1:0]      ptr,
  output logic [WAYS-1:0] gnt,
  output logic [1:0]      idx
);

  logic [3:0] req4_s;
  logic [3:0] gnt4_s;
  logic [1:0] cand_s;
  logic [1:0] idx_s;
  logic       found_s;

  assign req4_s = 4'(req);

  // Scan requesters starting at ptr and take the first one found.
  always_comb begin
    gnt4_s  = 4'b0000;
    idx_s   = 2'd0;
    found_s = 1'b0;
    cand_s  = 2'd0;
    for (int k = 0; k < WAYS; k++) begin
      cand_s = wrap_way({1'b0, ptr} + 3'(k), 3'(WAYS));
      if (!found_s && req4_s[cand_s]) begin
        found_s = 1'b1;
        idx_s   = cand_s;
        gnt4_s  = 4'b0001 << cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign gnt = gnt4_s[WAYS-1:0];
  assign idx = idx_s;

endmodule

// File: rtl/dram_write_scheduler.sv
// DRAM write scheduler: round-robin grants one way buffer at a time, issues a
// single write command sized by w_block, then drains that way block by block
// and advances its write address. Optional build macro WRSCHED_FLUSH_EN adds a
// flush input that lets partially filled ways issue short bursts.
module dram_write_scheduler
  import wrsched_pkg::*;
#(
  parameter int unsigned WAYS      = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned BLK_BYTES = WRSCHED_BLK_BYTES
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  pchange,
  input  logic [WAYS*32-1:0]    base_addr,
  input  logic [31:0]           w_block,
  input  logic [WAYS*CNT_W-1:0] buf_cnt,
`ifdef WRSCHED_FLUSH_EN
  input  logic                  flush,
`endif
  output logic [WAYS-1:0]       buf_deq,
  output logic                  dram_req,
  input  logic                  dram_ready,
  output logic [31:0]           dram_addr,
  output logic [31:0]           dram_size,
  input  logic                  d_rdy,
  output logic [1:0]            sel_way,
  output logic                  busy,
  output logic [WAYS*32-1:0]    w_addr
);

  wrsched_state_e state_r, state_nx_s;

  logic [1:0]         sel_way_r;
  logic [1:0]         rr_ptr_r;
  logic [31:0]        dram_addr_r;
  logic [31:0]        dram_size_r;
  logic [31:0]        beat_r;
  logic               pend_r;
  logic [WAYS*32-1:0] w_addr_r;

  logic [31:0]        eff_blk_s;
  logic [WAYS-1:0]    full_req_s;
  logic [WAYS-1:0]    full_gnt_s;
  logic [1:0]         full_idx_s;
  logic               grant_s;
  logic [1:0]         grant_idx_s;
  logic [31:0]        grant_size_s;
  logic               reload_s;
  logic               last_beat_s;
  logic [3:0]         deq4_s;

  // A zero burst size still moves one block per grant.
  always_comb begin
    if (w_block == 32'd0) begin
      eff_blk_s = 32'd1;
    end else begin
      eff_blk_s = w_block;
    end
  end

  // A way is eligible for a full burst once it holds eff_blk blocks.
  always_comb begin
    full_req_s = '0;
    for (int i = 0; i < WAYS; i++) begin
      full_req_s[i] = (32'(buf_cnt[i*CNT_W +: CNT_W]) >= eff_blk_s);
    end
  end

  rr_arbiter #(.WAYS(WAYS)) u_arb_full (
    .req (full_req_s),
    .ptr (rr_ptr_r),
    .gnt (full_gnt_s),
    .idx (full_idx_s)
  );

`ifdef WRSCHED_FLUSH_EN
  logic [WAYS-1:0] part_req_s;
  logic [WAYS-1:0] part_gnt_s;
  logic [1:0]      part_idx_s;
  logic [31:0]     part_size_s;

  // During flush a non-empty way short of eff_blk may issue what it holds.
  always_comb begin
    part_req_s = '0;
    for (int i = 0; i < WAYS; i++) begin
      part_req_s[i] = flush &&
                      (32'(buf_cnt[i*CNT_W +: CNT_W]) != 32'd0) &&
                      (32'(buf_cnt[i*CNT_W +: CNT_W]) < eff_blk_s);
    end
  end

  rr_arbiter #(.WAYS(WAYS)) u_arb_part (
    .req (part_req_s),
    .ptr (rr_ptr_r),
    .gnt (part_gnt_s),
    .idx (part_idx_s)
  );

  assign part_size_s = 32'(buf_cnt[part_idx_s*CNT_W +: CNT_W]);
`endif

  // Pick the winning way and burst size; full-size requests beat partial ones.
  always_comb begin
    grant_s      = 1'b0;
    grant_idx_s  = 2'd0;
    grant_size_s = eff_blk_s;
    if (|full_gnt_s) begin
      grant_s      = 1'b1;
      grant_idx_s  = full_idx_s;
      grant_size_s = eff_blk_s;
    end else begin
`ifdef WRSCHED_FLUSH_EN
      if (|part_gnt_s) begin
        grant_s      = 1'b1;
        grant_idx_s  = part_idx_s;
        grant_size_s = part_size_s;
      end else begin
        grant_s      = 1'b0;
      end
`else
      grant_s = 1'b0;
`endif
    end
  end

  assign reload_s    = (state_r == IDLE) && (pchange || pend_r);
  assign last_beat_s = (state_r == DATA) && d_rdy && (beat_r == 32'd1);

  // Next-state logic: a phase reload in IDLE suppresses any grant that cycle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (reload_s) begin
          state_nx_s = IDLE;
        end else if (grant_s) begin
          state_nx_s = REQ;
        end else begin
          state_nx_s = IDLE;
        end
      end
      REQ: begin
        if (dram_ready) begin
          state_nx_s = DATA;
        end else begin
          state_nx_s = REQ;
        end
      end
      DATA: begin
        if (last_beat_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DATA;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Burst registers, per-way addresses, round-robin pointer and pending reload.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_way_r   <= 2'd0;
      rr_ptr_r    <= 2'd0;
      dram_addr_r <= 32'd0;
      dram_size_r <= 32'd0;
      beat_r      <= 32'd0;
      pend_r      <= 1'b0;
      w_addr_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (reload_s) begin
            w_addr_r <= base_addr;
            rr_ptr_r <= 2'd0;
            pend_r   <= 1'b0;
          end else if (grant_s) begin
            sel_way_r   <= grant_idx_s;
            dram_addr_r <= w_addr_r[grant_idx_s*32 +: 32];
            dram_size_r <= grant_size_s;
            beat_r      <= grant_size_s;
          end else begin
            pend_r <= 1'b0;
          end
        end
        REQ: begin
          if (pchange) begin
            pend_r <= 1'b1;
          end else begin
            pend_r <= pend_r;
          end
        end
        DATA: begin
          if (pchange) begin
            pend_r <= 1'b1;
          end else begin
            pend_r <= pend_r;
          end
          if (d_rdy) begin
            beat_r <= beat_r - 32'd1;
            if (beat_r == 32'd1) begin
              w_addr_r[sel_way_r*32 +: 32] <= w_addr_r[sel_way_r*32 +: 32] +
                                               (dram_size_r * 32'(BLK_BYTES));
              rr_ptr_r <= wrap_way({1'b0, sel_way_r} + 3'd1, 3'(WAYS));
            end else begin
              rr_ptr_r <= rr_ptr_r;
            end
          end else begin
            beat_r <= beat_r;
          end
        end
        default: begin
          pend_r <= pend_r;
        end
      endcase
    end
  end

  // Pop the granted way for every block the DRAM takes during DATA.
  always_comb begin
    if ((state_r == DATA) && d_rdy) begin
      deq4_s = 4'b0001 << sel_way_r;
    end else begin
      deq4_s = 4'b0000;
    end
  end

  assign buf_deq   = deq4_s[WAYS-1:0];
  assign dram_req  = (state_r == REQ);
  assign busy      = (state_r != IDLE);
  assign dram_addr = dram_addr_r;
  assign dram_size = dram_size_r;
  assign sel_way   = sel_way_r;
  assign w_addr    = w_addr_r;

endmodule

// File: tb/tb_dram_write_scheduler.sv
// Self-checking bench for dram_write_scheduler: a per-cycle vector table for
// reset, phase load and a single burst, then directed multi-cycle sequences.
module tb_dram_write_scheduler;

  localparam logic [127:0] BASES = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [127:0] B2    = {32'h0000_7000, 32'h0000_6000, 32'h0000_5000, 32'h0000_4000};
  localparam logic [127:0] B3    = {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFC0};

  logic         CLK = 1'b0;
  logic         RST;
  logic         pchange;
  logic [127:0] base_addr;
  logic [31:0]  w_block;
  logic [63:0]  buf_cnt;
  logic [3:0]   buf_deq;
  logic         dram_req;
  logic         dram_ready;
  logic [31:0]  dram_addr;
  logic [31:0]  dram_size;
  logic         d_rdy;
  logic [1:0]   sel_way;
  logic         busy;
  logic [127:0] w_addr;
`ifdef WRSCHED_FLUSH_EN
  logic         flush;
`endif

  int checks   = 0;
  int failures = 0;

  dram_write_scheduler dut (
    .CLK        (CLK),
    .RST        (RST),
    .pchange    (pchange),
    .base_addr  (base_addr),
    .w_block    (w_block),
    .buf_cnt    (buf_cnt),
`ifdef WRSCHED_FLUSH_EN
    .flush      (flush),
`endif
    .buf_deq    (buf_deq),
    .dram_req   (dram_req),
    .dram_ready (dram_ready),
    .dram_addr  (dram_addr),
    .dram_size  (dram_size),
    .d_rdy      (d_rdy),
    .sel_way    (sel_way),
    .busy       (busy),
    .w_addr     (w_addr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         rst;
    logic         pch;
    logic [31:0]  wblk;
    logic [63:0]  cnt;
    logic         rdy;
    logic         drdy;
    logic         e_busy;
    logic         e_req;
    logic [3:0]   e_deq;
    logic [1:0]   e_sel;
    logic [31:0]  e_addr;
    logic [31:0]  e_size;
    logic [127:0] e_waddr;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic rst, input logic pch, input logic [31:0] wblk,
                              input logic [63:0] cnt, input logic rdy, input logic drdy,
                              input logic e_busy, input logic e_req, input logic [3:0] e_deq,
                              input logic [1:0] e_sel, input logic [31:0] e_addr,
                              input logic [31:0] e_size, input logic [127:0] e_waddr);
    vec_t v;
    v.rst = rst; v.pch = pch; v.wblk = wblk; v.cnt = cnt; v.rdy = rdy; v.drdy = drdy;
    v.e_busy = e_busy; v.e_req = e_req; v.e_deq = e_deq; v.e_sel = e_sel;
    v.e_addr = e_addr; v.e_size = e_size; v.e_waddr = e_waddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven 2 time units after the rising edge.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_req();
    #1;
    for (int n = 0; n < 40; n++) begin
      if (dram_req) break;
      step();
      #1;
    end
    chk("req_seen", dram_req, 1);
  endtask

  task automatic drain(output int pops);
    pops = 0;
    #1;
    for (int n = 0; n < 40; n++) begin
      if (!busy) break;
      if (buf_deq != 4'h0) pops++;
      step();
      #1;
    end
    chk("drain_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  exp_way  [5];
    logic [31:0] exp_addr [5];
    int          pops;

    RST = 1'b1; pchange = 1'b0; base_addr = BASES; w_block = 32'd8;
    buf_cnt = 64'h0; dram_ready = 1'b1; d_rdy = 1'b1;
`ifdef WRSCHED_FLUSH_EN
    flush = 1'b0;
`endif

    tbl[0]  = mk(1'b1, 1'b0, 32'd8, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 32'h0, 32'd0, 128'h0);
    tbl[1]  = mk(1'b0, 1'b1, 32'd8, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 32'h0, 32'd0, 128'h0);
    tbl[2]  = mk(1'b0, 1'b0, 32'd8, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 32'h0, 32'd0, BASES);
    tbl[3]  = mk(1'b0, 1'b0, 32'd8, 64'h0000_0008_0000_0000, 1'b1, 1'b1,
                 1'b0, 1'b0, 4'h0, 2'd0, 32'h0, 32'd0, BASES);
    tbl[4]  = mk(1'b0, 1'b0, 32'd8, 64'h0000_0008_0000_0000, 1'b1, 1'b1,
                 1'b1, 1'b1, 4'h0, 2'd2, 32'h2000, 32'd8, BASES);
    for (int i = 5; i < 13; i++) begin
      tbl[i] = mk(1'b0, 1'b0, 32'd8, 64'h0, 1'b1, 1'b1,
                  1'b1, 1'b0, 4'b0100, 2'd2, 32'h2000, 32'd8, BASES);
    end
    tbl[13] = mk(1'b0, 1'b0, 32'd8, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 2'd2, 32'h2000, 32'd8,
                 {32'h3000, 32'h2200, 32'h1000, 32'h0});

    step();
    step();

    // Table: reset values, phase load, one 8-block burst from way 2.
    for (int i = 0; i < 14; i++) begin
      RST = tbl[i].rst; pchange = tbl[i].pch; w_block = tbl[i].wblk;
      buf_cnt = tbl[i].cnt; dram_ready = tbl[i].rdy; d_rdy = tbl[i].drdy;
      #1;
      chk($sformatf("v%0d_busy", i),   busy,      tbl[i].e_busy);
      chk($sformatf("v%0d_req", i),    dram_req,  tbl[i].e_req);
      chk($sformatf("v%0d_deq", i),    buf_deq,   tbl[i].e_deq);
      chk($sformatf("v%0d_sel", i),    sel_way,   tbl[i].e_sel);
      chk($sformatf("v%0d_addr", i),   dram_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_size", i),   dram_size, tbl[i].e_size);
      chk($sformatf("v%0d_waddr", i),  w_addr,    tbl[i].e_waddr);
      step();
    end

    // Round robin: all ways full, grants 0,1,2,3,0 after a pointer reset.
    pchange = 1'b1; buf_cnt = 64'h0;
    step();
    pchange = 1'b0;
    #1;
    chk("a_reload", w_addr, BASES);
    exp_way  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_addr = '{32'h0, 32'h1000, 32'h2000, 32'h3000, 32'h100};
    buf_cnt = 64'h0010_0010_0010_0010; w_block = 32'd4; dram_ready = 1'b1; d_rdy = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_req();
      chk($sformatf("a%0d_sel", g),  sel_way,   exp_way[g]);
      chk($sformatf("a%0d_addr", g), dram_addr, exp_addr[g]);
      chk($sformatf("a%0d_size", g), dram_size, 32'd4);
      if (g == 4) buf_cnt = 64'h0;
      step();
    end
    drain(pops);
    chk("a_last_pops", pops, 4);
    chk("a_waddr", w_addr, {32'h3100, 32'h2100, 32'h1100, 32'h0200});

    // Back-pressure: command held 5 cycles, then data every other cycle.
    buf_cnt = 64'h0000_0000_0004_0000; dram_ready = 1'b0; d_rdy = 1'b0;
    wait_req();
    chk("b_sel", sel_way, 2'd1);
    chk("b_addr0", dram_addr, 32'h1100);
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      chk($sformatf("b%0d_req", k),  dram_req,  1);
      chk($sformatf("b%0d_addr", k), dram_addr, 32'h1100);
      chk($sformatf("b%0d_size", k), dram_size, 32'd4);
    end
    buf_cnt = 64'h0; dram_ready = 1'b1;
    step();
    pops = 0;
    for (int k = 0; k < 12; k++) begin
      d_rdy = (k % 2 == 1);
      #1;
      if (buf_deq != 4'h0) begin
        pops++;
        chk("b_deq_way", buf_deq, 4'b0010);
      end
      step();
    end
    chk("b_pops", pops, 4);
    chk("b_busy", busy, 0);
    chk("b_waddr", w_addr, {32'h3100, 32'h2100, 32'h1200, 32'h0200});

    // Phase change mid-burst: burst finishes, reload on the following IDLE cycle.
    buf_cnt = 64'h0000_0004_0000_0000; dram_ready = 1'b1; d_rdy = 1'b0;
    wait_req();
    chk("c_addr", dram_addr, 32'h2100);
    step();
    buf_cnt = 64'h0; pchange = 1'b1; base_addr = B2;
    step();
    pchange = 1'b0; d_rdy = 1'b1;
    drain(pops);
    chk("c_pops", pops, 4);
    chk("c_waddr_old", w_addr, {32'h3100, 32'h2200, 32'h1200, 32'h0200});
    step();
    #1;
    chk("c_waddr_new", w_addr, B2);
    chk("c_busy", busy, 0);

    // Reset mid-burst aborts it: idle, reset values, no further pops.
    buf_cnt = 64'h0000_0000_0000_0004; d_rdy = 1'b1;
    wait_req();
    chk("d_sel", sel_way, 2'd0);
    chk("d_addr", dram_addr, 32'h4000);
    step();
    buf_cnt = 64'h0;
    #1;
    chk("d_deq", buf_deq, 4'b0001);
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    chk("d_busy", busy, 0);
    chk("d_req", dram_req, 0);
    chk("d_deq_rst", buf_deq, 4'h0);
    chk("d_addr_rst", dram_addr, 32'h0);
    chk("d_waddr_rst", w_addr, 128'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      chk($sformatf("d%0d_nopop", k), buf_deq, 4'h0);
    end

    // w_block = 0 gives single-block bursts; address wraps past 2^32.
    base_addr = B3; pchange = 1'b1;
    step();
    pchange = 1'b0; w_block = 32'd0; buf_cnt = 64'h0000_0000_0000_0001;
    wait_req();
    chk("e_size", dram_size, 32'd1);
    chk("e_addr", dram_addr, 32'hFFFF_FFC0);
    buf_cnt = 64'h0;
    drain(pops);
    chk("e_pops", pops, 1);
    chk("e_waddr", w_addr, 128'h0);

`ifdef WRSCHED_FLUSH_EN
    // Flush lets a 3-block way issue a short burst.
    flush = 1'b1; w_block = 32'd8; buf_cnt = 64'h0000_0000_0003_0000;
    wait_req();
    chk("f_sel", sel_way, 2'd1);
    chk("f_size", dram_size, 32'd3);
    buf_cnt = 64'h0;
    drain(pops);
    chk("f_pops", pops, 3);
    flush = 1'b0;
`else
    // Without flush, a partial way never issues.
    w_block = 32'd8; buf_cnt = 64'h0000_0000_0003_0000;
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      chk($sformatf("f%0d_idle", k), busy, 0);
    end
    buf_cnt = 64'h0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
